// File: rtl/rv32v_element_sequencer.sv
// rv32v_element_sequencer: issues element pairs of one vector instruction to two lanes; optional perf counters under RV32V_SEQ_PERF_EN
module rv32v_element_sequencer #(
  parameter int MAX_VL = 128,
  parameter int VL_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [VL_W-1:0]   vl,
  input  logic [VL_W-1:0]   vstart,
  input  logic              is_masked,
  input  logic [MAX_VL-1:0] v0_mask,
  input  logic              vd_widen,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [VL_W-1:0]   woffset0,
  output logic [VL_W-1:0]   woffset1,
  output logic [VL_W:0]     vd_offset0,
  output logic [VL_W:0]     vd_offset1,
  output logic [1:0]        wen,
  output logic              busy,
  output logic              done,
  output logic [VL_W-1:0]   cur_vstart
`ifdef RV32V_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_pairs,
  output logic [31:0]       perf_masked_elems,
  output logic [31:0]       perf_stall_cycles
`endif
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [VL_W-1:0] e, vl_q;
  logic [MAX_VL-1:0] msk, sh0, sh1;
  logic masked_q, widen_q, done_q;
  logic run, in0, in1, w0, w1, fire, last, empty;
  logic [VL_W:0] e0, e1, e2, vlx;
  assign run = state == RUN;
  assign e0 = {1'b0, e};
  assign e1 = e0 + 1'b1;
  assign e2 = e0 + 2'd2;
  assign vlx = {1'b0, vl_q};
  assign sh0 = msk >> e0;
  assign sh1 = msk >> e1;
  assign in0 = e0 < vlx;
  assign in1 = e1 < vlx;
  assign w0 = in0 & (!masked_q | sh0[0]);
  assign w1 = in1 & (!masked_q | sh1[0]);
  assign fire = run & out_ready & !abort;
  assign last = e2 >= vlx;
  assign empty = vstart >= vl;
  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else state <= state_n;
  end
  // Next state and pair outputs; outputs are zero outside RUN
  always_comb begin
    state_n = abort ? IDLE : run ? ((fire & last) ? IDLE : RUN) : ((start & !empty) ? RUN : IDLE);
    out_valid = run;
    busy = run;
    woffset0 = run ? e : '0;
    woffset1 = run ? e1[VL_W-1:0] : '0;
    vd_offset0 = widen_q ? {woffset0, 1'b0} : {1'b0, woffset0};
    vd_offset1 = widen_q ? {woffset1, 1'b0} : {1'b0, woffset1};
    wen = run ? {w1, w0} : 2'b00;
    done = done_q | (fire & last);
  end
  // Element pointer, latched instruction fields and restart point
  always_ff @(posedge CLK) begin
    if (RST) begin
      e <= '0;
      vl_q <= '0;
      msk <= '0;
      masked_q <= 1'b0;
      widen_q <= 1'b0;
      done_q <= 1'b0;
      cur_vstart <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
      end else if (!run && start) begin
        vl_q <= vl;
        msk <= v0_mask;
        masked_q <= is_masked;
        widen_q <= vd_widen;
        e <= vstart;
        done_q <= empty;
        cur_vstart <= empty ? '0 : vstart;
      end else if (fire) begin
        e <= e2[VL_W-1:0];
        cur_vstart <= last ? '0 : e2[VL_W-1:0];
      end
    end
  end
`ifdef RV32V_SEQ_PERF_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction
  logic [1:0] n_masked;
  assign n_masked = {1'b0, in0 & !w0} + {1'b0, in1 & !w1};
  // Saturating performance counters, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_pairs <= '0;
      perf_masked_elems <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_pairs <= sat_add(perf_pairs, {1'b0, fire});
      perf_masked_elems <= sat_add(perf_masked_elems, fire ? n_masked : 2'd0);
      perf_stall_cycles <= sat_add(perf_stall_cycles, {1'b0, run & !out_ready});
    end
  end
`endif
endmodule
